// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   ID/EX pipeline stage that sits in front of MIPSALU. It registers the decoded
//   instruction and decodes ALUOp/funct into ALUctl at capture time. It builds the
//   A and B operands, forwarding from EX/MEM and MEM/WB where needed.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   stall, flush        hold the register contents / load a bubble (flush wins)
//   id_*                decoded instruction fields and register-file read data
//   exmem_*, memwb_*    downstream writeback info used for operand forwarding
//   ALUctl, A, B        connect 1:1 to MIPSALU
//   ex_store_data       forwarded rt value for stores
//   ex_dest             destination register index
//   ex_regwrite         register write enable
//   ex_valid            EX slot holds a real instruction
//   illegal             unsupported ALUOp/funct in the EX slot
module alu_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [15:0]        id_imm,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [5:0]         id_funct,
  input  logic [1:0]         id_aluop,
  input  logic               id_alusrc,
  input  logic               id_regdst,
  input  logic               id_regwrite,
  input  logic               exmem_regwrite,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_regwrite,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic [3:0]         ALUctl,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_dest,
  output logic               ex_regwrite,
  output logic               ex_valid,
  output logic               illegal
);

  localparam logic [3:0] CTL_AND     = 4'd0;
  localparam logic [3:0] CTL_OR      = 4'd1;
  localparam logic [3:0] CTL_ADD     = 4'd2;
  localparam logic [3:0] CTL_SUB     = 4'd6;
  localparam logic [3:0] CTL_SLT     = 4'd7;
  localparam logic [3:0] CTL_NOR     = 4'd12;
  localparam logic [3:0] CTL_ILLEGAL = 4'd15;

  // ID/EX register state
  logic               valid_q,    valid_d;
  logic               regwrite_q, regwrite_d;
  logic               illegal_q,  illegal_d;
  logic [3:0]         aluctl_q,   aluctl_d;
  logic [RADDR_W-1:0] rs_q,       rs_d;
  logic [RADDR_W-1:0] rt_q,       rt_d;
  logic [RADDR_W-1:0] dest_q,     dest_d;
  logic [DATA_W-1:0]  rs_data_q,  rs_data_d;
  logic [DATA_W-1:0]  rt_data_q,  rt_data_d;
  logic [15:0]        imm_q,      imm_d;
  logic               alusrc_q,   alusrc_d;

  // ALUctl decode of the incoming ID instruction
  logic [3:0] dec_ctl;
  logic       dec_bad;

  always_comb begin
    dec_ctl = CTL_ILLEGAL;
    dec_bad = 1'b0;
    case (id_aluop)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case (id_funct)
          6'h20:   dec_ctl = CTL_ADD;
          6'h22:   dec_ctl = CTL_SUB;
          6'h24:   dec_ctl = CTL_AND;
          6'h25:   dec_ctl = CTL_OR;
          6'h2A:   dec_ctl = CTL_SLT;
          6'h27:   dec_ctl = CTL_NOR;
          default: begin
            dec_ctl = CTL_ILLEGAL;
            dec_bad = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctl = CTL_ILLEGAL;
        dec_bad = 1'b1;
      end
    endcase
  end

  // Next-state selection: flush loads a bubble even when stalled; a stall
  // holds every register; otherwise the ID inputs are captured.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    illegal_d  = illegal_q;
    aluctl_d   = aluctl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dest_d     = dest_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      illegal_d  = 1'b0;
      aluctl_d   = 4'd0;
      rs_d       = '0;
      rt_d       = '0;
      dest_d     = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
    end else if (!stall) begin
      valid_d    = id_valid;
      // An illegal op never writes back, and an empty slot raises nothing.
      regwrite_d = id_valid & id_regwrite & ~dec_bad;
      illegal_d  = id_valid & dec_bad;
      aluctl_d   = dec_ctl;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dest_d     = id_regdst ? id_rd : id_rt;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      aluctl_q   <= 4'd0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
      aluctl_q   <= aluctl_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
    end
  end

  // Forwarding on the registered indices. EX/MEM is younger, so it wins over
  // MEM/WB. Register $0 is never forwarded.
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regwrite && (exmem_rd == rs_q) && (rs_q != '0)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwrite && (memwb_rd == rs_q) && (rs_q != '0)) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_regwrite && (exmem_rd == rt_q) && (rt_q != '0)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwrite && (memwb_rd == rt_q) && (rt_q != '0)) begin
      fwd_rt = memwb_result;
    end
  end

  assign A             = fwd_rs;
  assign B             = alusrc_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUctl        = aluctl_q;
  assign ex_dest       = dest_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_valid      = valid_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//   Directed self-checking bench for alu_operand_stage. Expected values are
//   hand-computed from the stage's intended behaviour.
module tb_alu_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc;
  logic        id_regdst;
  logic        id_regwrite;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_valid;
  logic        illegal;

  int testsRun   = 0;
  int testsFailed = 0;

  alu_operand_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_funct       (id_funct),
    .id_aluop       (id_aluop),
    .id_alusrc      (id_alusrc),
    .id_regdst      (id_regdst),
    .id_regwrite    (id_regwrite),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .ALUctl         (ALUctl),
    .A              (A),
    .B              (B),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_regwrite    (ex_regwrite),
    .ex_valid       (ex_valid),
    .illegal        (illegal)
  );

  always #5 clock = ~clock;

  // Advance one clock edge and settle 1 time unit past it before sampling.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  logic [5:0] functTab [5];
  logic [3:0] ctlTab   [5];

  initial begin
    functTab = '{6'h20, 6'h24, 6'h25, 6'h2A, 6'h27};
    ctlTab   = '{4'd2,  4'd0,  4'd1,  4'd7,  4'd12};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_aluop = '0;
    id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;

    // Reset held for two cycles
    applyStimulus();
    applyStimulus();
    checkOutput("reset_valid",    32'(ex_valid),    32'h0);
    checkOutput("reset_aluctl",   32'(ALUctl),      32'h0);
    checkOutput("reset_illegal",  32'(illegal),     32'h0);
    checkOutput("reset_regwrite", 32'(ex_regwrite), 32'h0);
    checkOutput("reset_A",        A,                32'h0);

    // R-type sub, no forwarding
    reset = 1'b0;
    id_valid = 1'b1; id_rs_data = 32'hD; id_rt_data = 32'h6;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    id_aluop = 2'b10; id_funct = 6'h22; id_alusrc = 1'b0;
    id_regdst = 1'b1; id_regwrite = 1'b1;
    applyStimulus();
    checkOutput("sub_aluctl",   32'(ALUctl),      32'd6);
    checkOutput("sub_A",        A,                32'hD);
    checkOutput("sub_B",        B,                32'h6);
    checkOutput("sub_dest",     32'(ex_dest),     32'd3);
    checkOutput("sub_regwrite", 32'(ex_regwrite), 32'h1);
    checkOutput("sub_valid",    32'(ex_valid),    32'h1);

    // addi with negative and positive immediates
    id_aluop = 2'b00; id_alusrc = 1'b1; id_imm = 16'hFFFE; id_regdst = 1'b0;
    applyStimulus();
    checkOutput("addi_aluctl", 32'(ALUctl),   32'd2);
    checkOutput("addi_B_neg",  B,             32'hFFFF_FFFE);
    checkOutput("addi_dest",   32'(ex_dest),  32'd2);
    checkOutput("addi_store",  ex_store_data, 32'h6);
    id_imm = 16'h7FFF;
    applyStimulus();
    checkOutput("addi_B_pos",  B,             32'h0000_7FFF);

    // R-type funct table
    id_aluop = 2'b10; id_alusrc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id_funct = functTab[i];
      applyStimulus();
      checkOutput($sformatf("funct_%02h", functTab[i]), 32'(ALUctl), 32'(ctlTab[i]));
    end

    // Forwarding priority on rs
    id_aluop = 2'b00; id_rs = 5'd3; id_rs_data = 32'h11;
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    applyStimulus();
    checkOutput("fwd_exmem_wins", A, 32'hAA);
    exmem_regwrite = 1'b0;
    #1;
    checkOutput("fwd_memwb", A, 32'hBB);

    // $0 is never forwarded; rt forwarded from MEM/WB into store data while B uses imm
    id_rs = 5'd0; id_rs_data = 32'h0; id_rt = 5'd5; id_rt_data = 32'h66;
    id_alusrc = 1'b1; id_imm = 16'h0010;
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
    applyStimulus();
    checkOutput("fwd_r0_A",    A,             32'h0);
    checkOutput("fwd_store",   ex_store_data, 32'hBB);
    checkOutput("fwd_B_imm",   B,             32'h10);

    // Stall three cycles while the ID inputs change
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    stall = 1'b1;
    id_aluop = 2'b10; id_funct = 6'h24; id_rs = 5'd7; id_rs_data = 32'h123;
    id_rt = 5'd9; id_rt_data = 32'h456; id_imm = 16'h8000; id_regdst = 1'b1; id_rd = 5'd12;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("stall_aluctl", 32'(ALUctl),      32'd2);
    checkOutput("stall_A",      A,                32'h0);
    checkOutput("stall_B",      B,                32'h10);
    checkOutput("stall_store",  ex_store_data,    32'h66);
    checkOutput("stall_dest",   32'(ex_dest),     32'd5);
    checkOutput("stall_valid",  32'(ex_valid),    32'h1);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hCC;
    #1;
    checkOutput("stall_fwd_live", ex_store_data, 32'hCC);

    // Flush beats stall
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush_valid",    32'(ex_valid),    32'h0);
    checkOutput("flush_regwrite", 32'(ex_regwrite), 32'h0);
    checkOutput("flush_dest",     32'(ex_dest),     32'h0);

    // Illegal funct
    flush = 1'b0; stall = 1'b0; exmem_regwrite = 1'b0;
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'h3F; id_regwrite = 1'b1;
    applyStimulus();
    checkOutput("ill_aluctl",   32'(ALUctl),      32'd15);
    checkOutput("ill_flag",     32'(illegal),     32'h1);
    checkOutput("ill_regwrite", 32'(ex_regwrite), 32'h0);
    id_valid = 1'b0;
    applyStimulus();
    checkOutput("ill_invalid_flag",   32'(illegal),  32'h0);
    checkOutput("ill_invalid_aluctl", 32'(ALUctl),   32'd15);

    // ALUOp 11 is illegal too
    id_valid = 1'b1; id_aluop = 2'b11; id_funct = 6'h20;
    applyStimulus();
    checkOutput("aluop11_flag", 32'(illegal), 32'h1);

    // Reset during a stall clears the stage
    id_aluop = 2'b00;
    applyStimulus();
    stall = 1'b1; reset = 1'b1;
    applyStimulus();
    checkOutput("rst_stall_valid",  32'(ex_valid), 32'h0);
    checkOutput("rst_stall_aluctl", 32'(ALUctl),   32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
